// File: rtl/fifo_wr_arbiter.sv
// Write-side scheduler for the async FIFO write domain: round-robin sharing of the
// single FIFO write port between a one-word requester and a two-word requester.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req0_i,
    input  logic [DATA_WIDTH-1:0]   data0_i,
    input  logic                    req1_i,
    input  logic [2*DATA_WIDTH-1:0] data1_i,
    input  logic                    wr_full_i,
    output logic                    wr_inc_o,
    output logic [DATA_WIDTH-1:0]   wr_data_o,
    output logic                    ack0_o,
    output logic                    ack1_o,
    output logic                    busy_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    sel_q, sel_d;
    logic                    last_q, last_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    ack0_q, ack0_d;
    logic                    ack1_q, ack1_d;

    logic                    m0;
    logic                    m1;
    logic                    grant_id;
    logic                    wr_inc;

    // A requester still shows its request during its own ACK cycle; mask it so
    // the same frame is not granted a second time.
    always_comb begin
        m0       = req0_i & ~ack0_q;
        m1       = req1_i & ~ack1_q;
        grant_id = (m0 && m1) ? ~last_q : m1;
        wr_inc   = ((state_q == SEND_LO) || (state_q == SEND_HI)) && !wr_full_i;
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0 || m1) begin
                    last_d  = grant_id;
                    sel_d   = grant_id;
                    state_d = SEND_LO;
                    if (grant_id) begin
                        wr_data_d = data1_i[DATA_WIDTH-1:0];
                        hold_d    = data1_i[2*DATA_WIDTH-1:DATA_WIDTH];
                    end else begin
                        wr_data_d = data0_i;
                    end
                end
            end

            SEND_LO: begin
                if (wr_inc) begin
                    if (!sel_q) begin
                        state_d = IDLE;
                        ack0_d  = 1'b1;
                    end else begin
                        wr_data_d = hold_q;
                        state_d   = SEND_HI;
                    end
                end
            end

            SEND_HI: begin
                if (wr_inc) begin
                    state_d = IDLE;
                    ack1_d  = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // last_q resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            last_q    <= 1'b1;
            wr_data_q <= '0;
            hold_q    <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
        end
    end

    assign wr_inc_o  = wr_inc;
    assign wr_data_o = wr_data_q;
    assign ack0_o    = ack0_q;
    assign ack1_o    = ack1_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Cycle-table bench for fifo_wr_arbiter; expected FIFO writes are checked via a scoreboard queue.
module tb_fifo_wr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req0_i;
    logic [7:0]  data0_i;
    logic        req1_i;
    logic [15:0] data1_i;
    logic        wr_full_i;
    logic        wr_inc_o;
    logic [7:0]  wr_data_o;
    logic        ack0_o;
    logic        ack1_o;
    logic        busy_o;

    fifo_wr_arbiter #(.DATA_WIDTH(8)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req0_i    (req0_i),
        .data0_i   (data0_i),
        .req1_i    (req1_i),
        .data1_i   (data1_i),
        .wr_full_i (wr_full_i),
        .wr_inc_o  (wr_inc_o),
        .wr_data_o (wr_data_o),
        .ack0_o    (ack0_o),
        .ack1_o    (ack1_o),
        .busy_o    (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        r0;
        logic [7:0]  d0;
        logic        r1;
        logic [15:0] d1;
        logic        full;
        logic        e_inc;
        logic        e_a0;
        logic        e_a1;
        logic        e_busy;
        logic        chk_d;
        logic [7:0]  e_d;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    function automatic void add(input logic r0, input logic [7:0] d0, input logic r1,
                                input logic [15:0] d1, input logic full, input logic e_inc,
                                input logic e_a0, input logic e_a1, input logic e_busy,
                                input logic chk_d, input logic [7:0] e_d);
        vec_t v;
        v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.full = full;
        v.e_inc = e_inc; v.e_a0 = e_a0; v.e_a1 = e_a1; v.e_busy = e_busy;
        v.chk_d = chk_d; v.e_d = e_d;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive just after the rising edge, sample at the falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        @(posedge clk_i);
        #1;
        req0_i    = v.r0;
        data0_i   = v.d0;
        req1_i    = v.r1;
        data1_i   = v.d1;
        wr_full_i = v.full;
        @(negedge clk_i);
        $display("vec %0d: r0=%b r1=%b full=%b -> inc=%b data=%h ack0=%b ack1=%b busy=%b",
                 idx, v.r0, v.r1, v.full, wr_inc_o, wr_data_o, ack0_o, ack1_o, busy_o);
        chk("wr_inc", {15'd0, wr_inc_o}, {15'd0, v.e_inc});
        chk("ack0",   {15'd0, ack0_o},   {15'd0, v.e_a0});
        chk("ack1",   {15'd0, ack1_o},   {15'd0, v.e_a1});
        chk("busy",   {15'd0, busy_o},   {15'd0, v.e_busy});
        if (v.chk_d) chk("wr_data", {8'd0, wr_data_o}, {8'd0, v.e_d});
        if (wr_inc_o) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_write: got unexpected write %h, expected none", wr_data_o);
            end else begin
                chk("sb_data", {8'd0, wr_data_o}, {8'd0, exp_q.pop_front()});
            end
        end
    endtask

    task automatic run_table(input string seg);
        $display("-- segment %s (%0d cycles)", seg, tbl.size());
        foreach (tbl[i]) run_vec(tbl[i], i);
        tbl.delete();
    endtask

    task automatic sb_empty(input string seg);
        chk({"sb_empty_", seg}, exp_q.size()[15:0], 16'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_ni = 1'b0; req0_i = 1'b0; data0_i = '0; req1_i = 1'b0; data1_i = '0; wr_full_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_inc",  {15'd0, wr_inc_o}, 16'd0);
        chk("rst_data", {8'd0, wr_data_o}, 16'd0);
        chk("rst_ack0", {15'd0, ack0_o},   16'd0);
        chk("rst_ack1", {15'd0, ack1_o},   16'd0);
        chk("rst_busy", {15'd0, busy_o},   16'd0);
        rst_ni = 1'b1;

        // Tie straight after reset: requester 0 goes first.
        exp_q.push_back(8'h01); exp_q.push_back(8'h02); exp_q.push_back(8'h03);
        add(1, 8'h01, 1, 16'h0302, 0, 0, 0, 0, 0, 0, 8'h00);
        add(1, 8'h01, 1, 16'h0302, 0, 1, 0, 0, 1, 1, 8'h01);
        add(1, 8'h01, 1, 16'h0302, 0, 0, 1, 0, 0, 0, 8'h00);
        add(0, 8'h01, 1, 16'h0302, 0, 1, 0, 0, 1, 1, 8'h02);
        add(0, 8'h01, 1, 16'h0302, 0, 1, 0, 0, 1, 1, 8'h03);
        add(0, 8'h01, 1, 16'h0302, 0, 0, 0, 1, 0, 0, 8'h00);
        add(0, 8'h01, 0, 16'h0302, 0, 0, 0, 0, 0, 0, 8'h00);
        run_table("first_tie");
        sb_empty("first_tie");

        // Single byte frame.
        exp_q.push_back(8'hA5);
        add(1, 8'hA5, 0, 16'h0, 0, 0, 0, 0, 0, 0, 8'h00);
        add(1, 8'hA5, 0, 16'h0, 0, 1, 0, 0, 1, 1, 8'hA5);
        add(1, 8'hA5, 0, 16'h0, 0, 0, 1, 0, 0, 0, 8'h00);
        add(0, 8'hA5, 0, 16'h0, 0, 0, 0, 0, 0, 0, 8'h00);
        run_table("byte0");
        sb_empty("byte0");

        // Two-byte frame, LSB first.
        exp_q.push_back(8'h34); exp_q.push_back(8'h12);
        add(0, 8'h00, 1, 16'h1234, 0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 1, 16'h1234, 0, 1, 0, 0, 1, 1, 8'h34);
        add(0, 8'h00, 1, 16'h1234, 0, 1, 0, 0, 1, 1, 8'h12);
        add(0, 8'h00, 1, 16'h1234, 0, 0, 0, 1, 0, 0, 8'h00);
        add(0, 8'h00, 0, 16'h1234, 0, 0, 0, 0, 0, 0, 8'h00);
        run_table("byte1");
        sb_empty("byte1");

        // Both held: round-robin alternation.
        exp_q.push_back(8'h11); exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
        exp_q.push_back(8'h11); exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
        add(1, 8'h11, 1, 16'hBBAA, 0, 0, 0, 0, 0, 0, 8'h00);
        add(1, 8'h11, 1, 16'hBBAA, 0, 1, 0, 0, 1, 1, 8'h11);
        add(1, 8'h11, 1, 16'hBBAA, 0, 0, 1, 0, 0, 0, 8'h00);
        add(1, 8'h11, 1, 16'hBBAA, 0, 1, 0, 0, 1, 1, 8'hAA);
        add(1, 8'h11, 1, 16'hBBAA, 0, 1, 0, 0, 1, 1, 8'hBB);
        add(1, 8'h11, 1, 16'hBBAA, 0, 0, 0, 1, 0, 0, 8'h00);
        add(1, 8'h11, 1, 16'hBBAA, 0, 1, 0, 0, 1, 1, 8'h11);
        add(1, 8'h11, 1, 16'hBBAA, 0, 0, 1, 0, 0, 0, 8'h00);
        add(0, 8'h11, 1, 16'hBBAA, 0, 1, 0, 0, 1, 1, 8'hAA);
        add(0, 8'h11, 1, 16'hBBAA, 0, 1, 0, 0, 1, 1, 8'hBB);
        add(0, 8'h11, 1, 16'hBBAA, 0, 0, 0, 1, 0, 0, 8'h00);
        add(0, 8'h11, 0, 16'hBBAA, 0, 0, 0, 0, 0, 0, 8'h00);
        run_table("alternate");
        sb_empty("alternate");

        // Stall between LSB and MSB; requester 0 arrives during the stall and waits.
        exp_q.push_back(8'hEF); exp_q.push_back(8'hCD); exp_q.push_back(8'h66);
        add(0, 8'h66, 1, 16'hCDEF, 0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 8'h66, 1, 16'hCDEF, 0, 1, 0, 0, 1, 1, 8'hEF);
        add(1, 8'h66, 1, 16'hCDEF, 1, 0, 0, 0, 1, 1, 8'hCD);
        add(1, 8'h66, 1, 16'hCDEF, 1, 0, 0, 0, 1, 1, 8'hCD);
        add(1, 8'h66, 1, 16'hCDEF, 1, 0, 0, 0, 1, 1, 8'hCD);
        add(1, 8'h66, 1, 16'hCDEF, 0, 1, 0, 0, 1, 1, 8'hCD);
        add(1, 8'h66, 1, 16'hCDEF, 0, 0, 0, 1, 0, 0, 8'h00);
        add(1, 8'h66, 0, 16'hCDEF, 0, 1, 0, 0, 1, 1, 8'h66);
        add(1, 8'h66, 0, 16'hCDEF, 0, 0, 1, 0, 0, 0, 8'h00);
        add(0, 8'h66, 0, 16'hCDEF, 0, 0, 0, 0, 0, 0, 8'h00);
        run_table("mid_stall");
        sb_empty("mid_stall");

        // FIFO full at grant time.
        exp_q.push_back(8'h5A);
        add(1, 8'h5A, 0, 16'h0, 1, 0, 0, 0, 0, 0, 8'h00);
        add(1, 8'h5A, 0, 16'h0, 1, 0, 0, 0, 1, 1, 8'h5A);
        add(1, 8'h5A, 0, 16'h0, 1, 0, 0, 0, 1, 1, 8'h5A);
        add(1, 8'h5A, 0, 16'h0, 0, 1, 0, 0, 1, 1, 8'h5A);
        add(1, 8'h5A, 0, 16'h0, 0, 0, 1, 0, 0, 0, 8'h00);
        add(0, 8'h5A, 0, 16'h0, 0, 0, 0, 0, 0, 0, 8'h00);
        run_table("full_grant");
        sb_empty("full_grant");

        // Reset while the MSB is stalled in SEND_HI: frame abandoned, no ACK, 77 never written.
        exp_q.push_back(8'h88);
        add(0, 8'h00, 1, 16'h7788, 0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 8'h00, 1, 16'h7788, 0, 1, 0, 0, 1, 1, 8'h88);
        add(0, 8'h00, 1, 16'h7788, 1, 0, 0, 0, 1, 1, 8'h77);
        run_table("pre_reset");
        rst_ni = 1'b0;
        #1;
        $display("mid-frame reset: inc=%b data=%h ack1=%b busy=%b", wr_inc_o, wr_data_o, ack1_o, busy_o);
        chk("mrst_inc",  {15'd0, wr_inc_o}, 16'd0);
        chk("mrst_data", {8'd0, wr_data_o}, 16'd0);
        chk("mrst_ack1", {15'd0, ack1_o},   16'd0);
        chk("mrst_busy", {15'd0, busy_o},   16'd0);
        req1_i = 1'b0;
        wr_full_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        add(0, 8'h00, 0, 16'h7788, 0, 0, 0, 0, 0, 1, 8'h00);
        add(0, 8'h00, 0, 16'h7788, 0, 0, 0, 0, 0, 1, 8'h00);
        add(0, 8'h00, 0, 16'h7788, 0, 0, 0, 0, 0, 1, 8'h00);
        run_table("post_reset");
        sb_empty("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side scheduler for the async FIFO write domain. It shares the single FIFO write port between two requesters:
- Requester 0: register-file read data, one byte per frame.
- Requester 1: ALU result, two bytes per frame, LSB first.
Arbitration is round-robin and frames are atomic. The block drives the FIFO write pointer increment and write data, honours the FIFO full flag, and sits in the FIFO write clock domain between the system controller and the FIFO write logic.

Parameters:
- DATA_WIDTH, 8, width of one FIFO word; requester 1 data is 2*DATA_WIDTH.

Ports:
- CLK  input  1  FIFO write-domain clock; all flops on rising edge.
- RST  input  1  asynchronous active-low reset.
- REQ0  input  1  requester 0 has a byte pending; held until ACK0.
- DATA0  input  DATA_WIDTH  requester 0 byte; stable while REQ0=1.
- REQ1  input  1  requester 1 has a word pending; held until ACK1.
- DATA1  input  2*DATA_WIDTH  requester 1 word; [DATA_WIDTH-1:0] is sent first.
- WR_FULL  input  1  FIFO full flag from FIFO write logic.
- WR_INC  output  1  FIFO write strobe; one word written per cycle high.
- WR_DATA  output  DATA_WIDTH  word presented to FIFO memory.
- ACK0  output  1  one-cycle pulse: requester 0 frame fully written.
- ACK1  output  1  one-cycle pulse: requester 1 frame fully written.
- BUSY  output  1  high whenever state != IDLE.

Behaviour:
- Reset (RST=0, async): state=IDLE, WR_DATA=0, hold register=0, ACK0=ACK1=0, LAST=1 (requester 0 wins the first tie). WR_INC=0 and BUSY=0 follow from IDLE.
- States: IDLE, SEND_LO, SEND_HI.
- IDLE: form the masked requests M0=REQ0&!ACK0 and M1=REQ1&!ACK1. This drops the request a requester still shows during its own ACK cycle.
  - Only M0: grant 0. Only M1: grant 1. Both: grant the requester != LAST.
  - On grant: LAST<=grant id; SEL<=grant id; state<=SEND_LO.
  - Grant 0: WR_DATA<=DATA0. Grant 1: WR_DATA<=DATA1 low half; HOLD<=DATA1 high half.
  - No request: stay in IDLE; WR_DATA holds its value.
- WR_INC = (state==SEND_LO || state==SEND_HI) && !WR_FULL. It is combinational from registered state and the WR_FULL input. It is never high in IDLE.
- SEND_LO, edge with WR_INC=1:
  - SEL=0: state<=IDLE, ACK0<=1.
  - SEL=1: WR_DATA<=HOLD, state<=SEND_HI.
- SEND_HI, edge with WR_INC=1: state<=IDLE, ACK1<=1.
- WR_FULL=1 in SEND_LO/SEND_HI: hold state and WR_DATA, WR_INC=0. No byte is lost or duplicated.
- A stall may occur between the LSB and the MSB. The frame is never split by the other requester.
- ACKx is high for exactly one cycle, in the cycle the FSM is back in IDLE. Otherwise ACKx<=0.
- Latency, FIFO never full: REQ sampled at edge n.
  - Byte-0 frame: WR_INC high in cycle n+1; ACK0 in cycle n+2.
  - Byte-1 frame: WR_INC high in cycles n+1 and n+2; ACK1 in cycle n+3.
  - Next grant is earliest at the ACK-cycle edge, so there is one idle cycle between frames.
- Throughput: back-to-back alternating requesters are served fairly. A requester is never granted twice while the other is pending.
- REQx dropped before ACK: ignored. Data is already captured and the frame completes.
- Reset mid-frame: the frame is abandoned, no ACK is issued, and all state returns to reset values immediately.
- Width rule: DATA1 split exactly at bit DATA_WIDTH; no arithmetic on data.

Test Plan:
- Reset then REQ0=1, DATA0=8'hA5, WR_FULL=0 -> WR_INC one cycle with WR_DATA=A5, ACK0 pulse next cycle, BUSY high for 1 cycle.
- REQ1=1, DATA1=16'h1234, WR_FULL=0 -> WR_INC two consecutive cycles with WR_DATA=34 then 12, then ACK1 pulse.
- REQ0 and REQ1 both held continuously (DATA0=11, DATA1=BBAA) -> FIFO write sequence 11, AA, BB, 11, AA, BB; ACK0/ACK1 alternate.
- REQ1 with DATA1=16'hCDEF; WR_FULL=1 after the LSB write for 3 cycles -> EF written, WR_INC=0 and WR_DATA=CD for 3 cycles, then CD written, then ACK1. REQ0 raised during the stall waits until after ACK1.
- WR_FULL=1 at grant time with REQ0, DATA0=5A -> no write while full; writes 5A on the first cycle with WR_FULL=0.
- RST asserted in SEND_HI of a DATA1=16'h7788 frame (88 already written) -> outputs at reset values immediately, no ACK1, 77 never written.
